// File: rtl/riscv_pkg.sv
// RV32I load/store encodings, LSU state enum and request legality helper.
// Latency: none (declarations only).
// Backpressure: not applicable.
package riscv_pkg;

  localparam int WORD_BYTES = 4;

  // Load funct3 codes
  localparam logic [2:0] F3_LB  = 3'd0;
  localparam logic [2:0] F3_LH  = 3'd1;
  localparam logic [2:0] F3_LW  = 3'd2;
  localparam logic [2:0] F3_LBU = 3'd4;
  localparam logic [2:0] F3_LHU = 3'd5;

  // Store funct3 codes
  localparam logic [2:0] F3_SB  = 3'd0;
  localparam logic [2:0] F3_SH  = 3'd1;
  localparam logic [2:0] F3_SW  = 3'd2;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_READ  = 3'd1,
    ST_MERGE = 3'd2,
    ST_WRITE = 3'd3,
    ST_RESP  = 3'd4,
    ST_ERR   = 3'd5
  } lsu_state_e;

  // Encoding and alignment legality; the address range is checked by the caller.
  function automatic logic lsu_req_ok(input logic we, input logic [2:0] f3,
                                      input logic [1:0] addr_lo);
    logic f3_ok;
    logic align_ok;
    if (we) f3_ok = (f3 == F3_SB) || (f3 == F3_SH) || (f3 == F3_SW);
    else    f3_ok = (f3 == F3_LB) || (f3 == F3_LH) || (f3 == F3_LW) ||
                    (f3 == F3_LBU) || (f3 == F3_LHU);
    case (f3[1:0])
      2'd1:    align_ok = ~addr_lo[0];
      2'd2:    align_ok = (addr_lo == 2'b00);
      default: align_ok = 1'b1;
    endcase
    return f3_ok && align_ok;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Lane steering: extracts and extends load data, merges byte/half store data into a word.
// Latency: purely combinational.
// Backpressure: none; outputs follow inputs.
module lsu_align
  import riscv_pkg::*;
(
  input  logic [2:0]  funct3_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [31:0] word_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] load_data_o,
  output logic [31:0] store_word_o
);

  logic [4:0]  byte_sh;
  logic [4:0]  half_sh;
  logic [31:0] byte_lane;
  logic [31:0] half_lane;

  assign byte_sh   = {addr_lo_i, 3'b000};
  assign half_sh   = {addr_lo_i[1], 4'b0000};
  assign byte_lane = word_i >> byte_sh;
  assign half_lane = word_i >> half_sh;

  // Pick the addressed lane and sign/zero extend it to 32 bits.
  always_comb begin
    load_data_o = word_i;
    case (funct3_i)
      F3_LB:   load_data_o = {{24{byte_lane[7]}}, byte_lane[7:0]};
      F3_LH:   load_data_o = {{16{half_lane[15]}}, half_lane[15:0]};
      F3_LBU:  load_data_o = {24'h000000, byte_lane[7:0]};
      F3_LHU:  load_data_o = {16'h0000, half_lane[15:0]};
      default: load_data_o = word_i;
    endcase
  end

  // Replace only the addressed lane of the old word; other lanes pass through.
  always_comb begin
    store_word_o = wdata_i;
    case (funct3_i)
      F3_SB:   store_word_o = (word_i & ~(32'h000000FF << byte_sh)) |
                              ({24'h000000, wdata_i[7:0]} << byte_sh);
      F3_SH:   store_word_o = (word_i & ~(32'h0000FFFF << half_sh)) |
                              ({16'h0000, wdata_i[15:0]} << half_sh);
      default: store_word_o = wdata_i;
    endcase
  end

endmodule

// File: rtl/lsu_mem_master.sv
// Single-outstanding RV32I load/store initiator to a word-wide, 1-cycle-read data memory.
// Latency: load 2 cycles, SW 1, SB/SH 3 (read-modify-write), error 1, accept to response.
// Backpressure: req_ready_o low from accept until the response cycle completes.
module lsu_mem_master
  import riscv_pkg::*;
#(
  parameter int unsigned MEM_BYTES = 512
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_we_i,
  input  logic [2:0]  req_funct3_i,
  input  logic [31:0] req_addr_i,
  input  logic [31:0] req_wdata_i,
  output logic        resp_valid_o,
  output logic [31:0] resp_rdata_o,
  output logic        resp_err_o,
  output logic        mem_re_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic [31:0] mem_rdata_i
);

  lsu_state_e  state_q;
  logic        we_q;
  logic [2:0]  funct3_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic        mem_re_q;
  logic        mem_we_q;
  logic [31:0] mem_addr_q;
  logic [31:0] mem_wdata_q;
  logic        resp_valid_q;
  logic        resp_err_q;

  logic [31:0] req_word_addr;
  logic        req_ok;
  logic [31:0] load_data;
  logic [31:0] store_word;

  assign req_word_addr = {req_addr_i[31:2], 2'b00};
  assign req_ok        = lsu_req_ok(req_we_i, req_funct3_i, req_addr_i[1:0]) &&
                         (req_word_addr < 32'(MEM_BYTES));

  // Read data arrives combinationally in RESP/MERGE, so steering works on the live memory word.
  lsu_align u_align (
    .funct3_i     (funct3_q),
    .addr_lo_i    (addr_q[1:0]),
    .word_i       (mem_rdata_i),
    .wdata_i      (wdata_q),
    .load_data_o  (load_data),
    .store_word_o (store_word)
  );

  assign req_ready_o  = (state_q == ST_IDLE);
  assign mem_re_o     = mem_re_q;
  assign mem_we_o     = mem_we_q;
  assign mem_addr_o   = mem_addr_q;
  assign mem_wdata_o  = mem_wdata_q;
  assign resp_valid_o = resp_valid_q;
  assign resp_err_o   = resp_err_q;
  assign resp_rdata_o = (state_q == ST_RESP) ? load_data : 32'h0;

  // Control FSM with request latch; memory/response strobes are one-cycle registered pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      we_q         <= 1'b0;
      funct3_q     <= 3'd0;
      addr_q       <= 32'h0;
      wdata_q      <= 32'h0;
      mem_re_q     <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= 32'h0;
      mem_wdata_q  <= 32'h0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
    end else begin
      mem_re_q     <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= 32'h0;
      mem_wdata_q  <= 32'h0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (req_valid_i) begin
            we_q     <= req_we_i;
            funct3_q <= req_funct3_i;
            addr_q   <= req_addr_i;
            wdata_q  <= req_wdata_i;
            if (!req_ok) begin
              state_q      <= ST_ERR;
              resp_valid_q <= 1'b1;
              resp_err_q   <= 1'b1;
            end else if (req_we_i && (req_funct3_i == F3_SW)) begin
              // Full-word store needs no read of the old contents.
              state_q      <= ST_WRITE;
              mem_we_q     <= 1'b1;
              mem_addr_q   <= req_word_addr;
              mem_wdata_q  <= req_wdata_i;
              resp_valid_q <= 1'b1;
            end else begin
              state_q    <= ST_READ;
              mem_re_q   <= 1'b1;
              mem_addr_q <= req_word_addr;
            end
          end
        end
        ST_READ: begin
          if (we_q) begin
            state_q <= ST_MERGE;
          end else begin
            state_q      <= ST_RESP;
            resp_valid_q <= 1'b1;
          end
        end
        ST_MERGE: begin
          state_q      <= ST_WRITE;
          mem_we_q     <= 1'b1;
          mem_addr_q   <= {addr_q[31:2], 2'b00};
          mem_wdata_q  <= store_word;
          resp_valid_q <= 1'b1;
        end
        ST_WRITE, ST_RESP, ST_ERR: state_q <= ST_IDLE;
        default:                   state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_mem_master.sv
// Randomised and directed bench for lsu_mem_master with a per-cycle expectation schedule.
// Latency: n/a.
// Backpressure: n/a.
module tb_lsu_mem_master;

  localparam int MEMB = 512;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid_i = 1'b0;
  logic        req_ready_o;
  logic        req_we_i = 1'b0;
  logic [2:0]  req_funct3_i = 3'd0;
  logic [31:0] req_addr_i = 32'h0;
  logic [31:0] req_wdata_i = 32'h0;
  logic        resp_valid_o;
  logic [31:0] resp_rdata_o;
  logic        resp_err_o;
  logic        mem_re_o;
  logic        mem_we_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic [31:0] mem_rdata_i = 32'h0;

  int checks = 0;
  int errors = 0;

  logic [7:0] env_mem [0:MEMB-1];
  logic [7:0] ref_mem [0:MEMB-1];

  typedef struct packed {
    logic        rdy;
    logic        re;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        rv;
    logic        err;
    logic [31:0] rdata;
  } exp_t;

  exp_t exp_q [$];

  lsu_mem_master #(.MEM_BYTES(MEMB)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid_i  (req_valid_i),
    .req_ready_o  (req_ready_o),
    .req_we_i     (req_we_i),
    .req_funct3_i (req_funct3_i),
    .req_addr_i   (req_addr_i),
    .req_wdata_i  (req_wdata_i),
    .resp_valid_o (resp_valid_o),
    .resp_rdata_o (resp_rdata_o),
    .resp_err_o   (resp_err_o),
    .mem_re_o     (mem_re_o),
    .mem_we_o     (mem_we_o),
    .mem_addr_o   (mem_addr_o),
    .mem_wdata_o  (mem_wdata_o),
    .mem_rdata_i  (mem_rdata_i)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Byte-addressed data memory with a registered read port.
  always @(posedge clk) begin
    int i;
    i = int'(mem_addr_o);
    if (mem_re_o && i >= 0 && i <= MEMB - 4)
      mem_rdata_i <= {env_mem[i+3], env_mem[i+2], env_mem[i+1], env_mem[i]};
    if (mem_we_o && i >= 0 && i <= MEMB - 4) begin
      env_mem[i]   <= mem_wdata_o[7:0];
      env_mem[i+1] <= mem_wdata_o[15:8];
      env_mem[i+2] <= mem_wdata_o[23:16];
      env_mem[i+3] <= mem_wdata_o[31:24];
    end
  end

  // Reference model: turns one accepted request into its expected cycle-by-cycle outputs.
  task automatic model_accept(input logic we, input logic [2:0] f3,
                              input logic [31:0] a, input logic [31:0] wd);
    exp_t        e0, e1, e2;
    int          size, off;
    logic        ok;
    logic [31:0] al, v;
    logic [7:0]  b [4];
    e0 = '0; e1 = '0; e2 = '0;
    al   = {a[31:2], 2'b00};
    off  = int'(a[1:0]);
    size = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
    ok   = we ? (f3 <= 3'd2) : (f3 <= 3'd2 || f3 == 3'd4 || f3 == 3'd5);
    if ((off % size) != 0) ok = 1'b0;
    if (al >= 32'(MEMB))   ok = 1'b0;
    if (!ok) begin
      e0.rv = 1'b1; e0.err = 1'b1;
      exp_q.push_back(e0);
    end else if (!we) begin
      v = 32'h0;
      for (int k = size - 1; k >= 0; k--) v = (v << 8) | 32'(ref_mem[int'(a) + k]);
      if (!f3[2] && size < 4 && v[size*8-1]) v = v | (32'hFFFFFFFF << (size * 8));
      e0.re = 1'b1; e0.addr = al;
      e1.rv = 1'b1; e1.rdata = v;
      exp_q.push_back(e0);
      exp_q.push_back(e1);
    end else begin
      for (int k = 0; k < 4; k++) b[k] = ref_mem[int'(al) + k];
      for (int k = 0; k < size; k++) b[off + k] = wd[8*k +: 8];
      e2.we = 1'b1; e2.addr = al; e2.wdata = {b[3], b[2], b[1], b[0]}; e2.rv = 1'b1;
      if (size == 4) begin
        exp_q.push_back(e2);
      end else begin
        e0.re = 1'b1; e0.addr = al;
        exp_q.push_back(e0);
        exp_q.push_back(e1);
        exp_q.push_back(e2);
      end
    end
  endtask

  // Every cycle: compare all outputs to the schedule, commit expected writes, record accepts.
  always @(negedge clk) begin
    exp_t e, act;
    e = '0;
    e.rdy = 1'b1;
    if (rst) exp_q.delete();
    else if (exp_q.size() > 0) e = exp_q.pop_front();
    act = {req_ready_o, mem_re_o, mem_we_o, mem_addr_o, mem_wdata_o,
           resp_valid_o, resp_err_o, resp_rdata_o};
    checks++;
    if (act !== e) begin
      errors++;
      $display("FAIL cycle t=%0t: got rdy=%b re=%b we=%b a=%h wd=%h rv=%b err=%b rd=%h expected rdy=%b re=%b we=%b a=%h wd=%h rv=%b err=%b rd=%h",
               $time, act.rdy, act.re, act.we, act.addr, act.wdata, act.rv, act.err, act.rdata,
               e.rdy, e.re, e.we, e.addr, e.wdata, e.rv, e.err, e.rdata);
    end
    if (!rst && e.we) begin
      for (int k = 0; k < 4; k++) ref_mem[int'(e.addr) + k] = e.wdata[8*k +: 8];
    end
    if (!rst && req_valid_i && req_ready_o)
      model_accept(req_we_i, req_funct3_i, req_addr_i, req_wdata_i);
  end

  // Present one request, wait for acceptance, then return the response and its latency.
  task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd, output logic [31:0] rd,
                        output logic er, output int lat);
    int n;
    @(posedge clk); #1;
    req_valid_i = 1'b1; req_we_i = we; req_funct3_i = f3; req_addr_i = a; req_wdata_i = wd;
    n = 0;
    while (!req_ready_o && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    @(posedge clk); #1;
    req_valid_i = 1'b0;
    lat = 0; rd = 32'h0; er = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (resp_valid_o) begin
        lat = k; rd = resp_rdata_o; er = resp_err_o;
        break;
      end
    end
  endtask

  initial begin
    logic [31:0] rd;
    logic        er;
    int          lat;
    int          w;

    for (int i = 0; i < MEMB; i++) begin
      env_mem[i] = 8'($urandom);
      ref_mem[i] = env_mem[i];
    end
    // Directed contents: 44 33 22 11 at 0x10 and word 0x11223344 at 0x20.
    for (int i = 0; i < 4; i++) begin
      env_mem[16 + i] = 8'(8'h44 - 8'(i * 8'h11));
      env_mem[32 + i] = env_mem[16 + i];
      ref_mem[16 + i] = env_mem[16 + i];
      ref_mem[32 + i] = env_mem[16 + i];
    end

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;
    check("reset_ready", 32'(req_ready_o), 32'h1);
    check("reset_outs", {26'h0, mem_re_o, mem_we_o, resp_valid_o, resp_err_o, 2'b00}, 32'h0);
    check("reset_addr", mem_addr_o, 32'h0);

    do_req(1'b0, 3'd2, 32'h10, 32'h0, rd, er, lat);
    check("lw_0x10_data", rd, 32'h11223344);
    check("lw_0x10_lat", 32'(lat), 32'd2);

    do_req(1'b1, 3'd2, 32'h10, 32'h80FF0000, rd, er, lat);
    check("sw_0x10_lat", 32'(lat), 32'd1);
    do_req(1'b0, 3'd0, 32'h13, 32'h0, rd, er, lat);
    check("lb_0x13", rd, 32'hFFFFFF80);
    do_req(1'b0, 3'd4, 32'h13, 32'h0, rd, er, lat);
    check("lbu_0x13", rd, 32'h00000080);
    do_req(1'b0, 3'd5, 32'h12, 32'h0, rd, er, lat);
    check("lhu_0x12", rd, 32'h000080FF);

    do_req(1'b1, 3'd0, 32'h21, 32'h000000AB, rd, er, lat);
    check("sb_0x21_lat", 32'(lat), 32'd3);
    check("sb_0x21_rdata", rd, 32'h0);
    do_req(1'b0, 3'd2, 32'h20, 32'h0, rd, er, lat);
    check("sb_0x21_word", rd, 32'h1122AB44);
    do_req(1'b1, 3'd1, 32'h22, 32'h1234BEEF, rd, er, lat);
    check("sh_0x22_lat", 32'(lat), 32'd3);
    do_req(1'b0, 3'd2, 32'h20, 32'h0, rd, er, lat);
    check("sh_0x22_word", rd, 32'hBEEFAB44);

    do_req(1'b1, 3'd2, 32'h05, 32'hDEADBEEF, rd, er, lat);
    check("sw_0x05_err", 32'(er), 32'h1);
    check("sw_0x05_lat", 32'(lat), 32'd1);
    do_req(1'b0, 3'd2, 32'h200, 32'h0, rd, er, lat);
    check("lw_0x200_err", 32'(er), 32'h1);
    check("lw_0x200_rdata", rd, 32'h0);
    do_req(1'b0, 3'd3, 32'h40, 32'h0, rd, er, lat);
    check("ld_f3_3_err", 32'(er), 32'h1);

    do_req(1'b1, 3'd2, 32'h40, 32'hCAFEF00D, rd, er, lat);
    do_req(1'b0, 3'd2, 32'h40, 32'h0, rd, er, lat);
    check("b2b_lw_data", rd, 32'hCAFEF00D);
    check("b2b_lw_err", 32'(er), 32'h0);

    // Reset while an SB sits in READ: the write must be dropped.
    @(posedge clk); #1;
    req_valid_i = 1'b1; req_we_i = 1'b1; req_funct3_i = 3'd0;
    req_addr_i = 32'h41; req_wdata_i = 32'h00000055;
    @(posedge clk); #1;
    req_valid_i = 1'b0;
    check("rst_mid_in_read", 32'(mem_re_o), 32'h1);
    rst = 1'b1;
    #1;
    check("rst_mid_outs", {28'h0, mem_re_o, mem_we_o, resp_valid_o, resp_err_o}, 32'h0);
    check("rst_mid_ready", 32'(req_ready_o), 32'h1);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    do_req(1'b0, 3'd2, 32'h40, 32'h0, rd, er, lat);
    check("rst_mid_no_write", rd, 32'hCAFEF00D);

    // Random traffic, inputs wiggling freely while the block is busy.
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk); #1;
      req_valid_i  = ($urandom_range(0, 3) != 0);
      req_we_i     = 1'($urandom_range(0, 1));
      req_funct3_i = ($urandom_range(0, 4) == 0) ? 3'($urandom) :
                     (req_we_i ? 3'($urandom_range(0, 2)) : 3'(($urandom_range(0, 4) + 1) % 6));
      if (req_funct3_i == 3'd3 && !req_we_i && $urandom_range(0, 1) == 1) req_funct3_i = 3'd4;
      w = $urandom_range(0, 135) * 4;
      req_addr_i   = 32'(w) + (($urandom_range(0, 1) == 1) ? 32'($urandom_range(0, 3)) : 32'h0);
      if ($urandom_range(0, 31) == 0) req_addr_i = $urandom;
      req_wdata_i  = $urandom;
    end
    @(posedge clk); #1;
    req_valid_i = 1'b0;
    repeat (8) @(posedge clk);
    #1;

    for (int i = 0; i < MEMB; i += 4)
      check($sformatf("mem_word_%0h", i),
            {env_mem[i+3], env_mem[i+2], env_mem[i+1], env_mem[i]},
            {ref_mem[i+3], ref_mem[i+2], ref_mem[i+1], ref_mem[i]});

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
